// File: rtl/spi_ram_arbiter_if.sv
// Bus bundle between the SPI slave, the local host, the shared RAM and the arbiter.
// The arbiter connects through the slave modport; the environment uses master.
interface spi_ram_arbiter_if #(
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH+1:0] spi_rx_data;
    logic                  spi_rx_valid;
    logic [ADDR_WIDTH-1:0] spi_tx_data;
    logic                  spi_tx_valid;

    logic                  host_req;
    logic                  host_we;
    logic [ADDR_WIDTH-1:0] host_addr;
    logic [ADDR_WIDTH-1:0] host_wdata;
    logic                  host_gnt;
    logic [ADDR_WIDTH-1:0] host_rdata;
    logic                  host_rvalid;

    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [ADDR_WIDTH-1:0] ram_wdata;
    logic [ADDR_WIDTH-1:0] ram_rdata;

    logic                  err_overflow;

    modport slave (
        input  spi_rx_data, spi_rx_valid, host_req, host_we, host_addr, host_wdata, ram_rdata,
        output spi_tx_data, spi_tx_valid, host_gnt, host_rdata, host_rvalid,
               ram_en, ram_we, ram_addr, ram_wdata, err_overflow
    );

    modport master (
        output spi_rx_data, spi_rx_valid, host_req, host_we, host_addr, host_wdata, ram_rdata,
        input  spi_tx_data, spi_tx_valid, host_gnt, host_rdata, host_rvalid,
               ram_en, ram_we, ram_addr, ram_wdata, err_overflow
    );
endinterface

// File: rtl/spi_ram_arbiter.sv
// Shares one single-port RAM between an unstallable SPI command stream and a req/gnt host,
// round-robin on contention, routing read data back to whoever issued the read.
module spi_ram_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    spi_ram_arbiter_if.slave    bus
);
    localparam int RAM_AW = $clog2(MEM_DEPTH);

    typedef enum logic {OWN_SPI = 1'b0, OWN_HOST = 1'b1} owner_e;

    typedef struct packed {
        logic                  we;
        logic [RAM_AW-1:0]     addr;
        logic [ADDR_WIDTH-1:0] wdata;
    } ram_cmd_t;

    typedef struct packed {
        logic   vld;
        owner_e owner;
    } tag_t;

    logic [1:0]            op;
    logic [ADDR_WIDTH-1:0] payload;
    logic                  host_elig, spi_win, host_win;

    logic [RAM_AW-1:0]     wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic                  spi_pend_q, spi_pend_d;
    ram_cmd_t              pend_cmd_q, pend_cmd_d;
    owner_e                last_grant_q, last_grant_d;
    tag_t [1:0]            tag_q, tag_d;

    logic                  ram_en_q, ram_en_d, ram_we_q, ram_we_d;
    logic [RAM_AW-1:0]     ram_addr_q, ram_addr_d;
    logic [ADDR_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
    logic                  host_gnt_q, host_gnt_d;
    logic [ADDR_WIDTH-1:0] spi_tx_data_q, spi_tx_data_d, host_rdata_q, host_rdata_d;
    logic                  spi_tx_valid_q, spi_tx_valid_d, host_rvalid_q, host_rvalid_d;
    logic                  err_overflow_q, err_overflow_d;

    always_comb begin
        op       = bus.spi_rx_data[ADDR_WIDTH+1:ADDR_WIDTH];
        payload  = bus.spi_rx_data[ADDR_WIDTH-1:0];

        // The cycle after a grant the host is ignored, so it gets at most every other slot.
        host_elig = bus.host_req && !host_gnt_q;
        spi_win   = spi_pend_q && (!host_elig || last_grant_q == OWN_HOST);
        host_win  = host_elig && !spi_win;

        wr_addr_d      = wr_addr_q;
        rd_addr_d      = rd_addr_q;
        spi_pend_d     = spi_pend_q;
        pend_cmd_d     = pend_cmd_q;
        last_grant_d   = last_grant_q;
        ram_en_d       = 1'b0;
        ram_we_d       = 1'b0;
        ram_addr_d     = ram_addr_q;
        ram_wdata_d    = ram_wdata_q;
        host_gnt_d     = 1'b0;
        spi_tx_data_d  = spi_tx_data_q;
        spi_tx_valid_d = 1'b0;
        host_rdata_d   = host_rdata_q;
        host_rvalid_d  = 1'b0;
        err_overflow_d = err_overflow_q;
        tag_d[0]       = '{vld: 1'b0, owner: OWN_SPI};
        tag_d[1]       = tag_q[0];

        if (spi_win) begin
            ram_en_d     = 1'b1;
            ram_we_d     = pend_cmd_q.we;
            ram_addr_d   = pend_cmd_q.addr;
            ram_wdata_d  = pend_cmd_q.wdata;
            spi_pend_d   = 1'b0;
            last_grant_d = OWN_SPI;
            tag_d[0]     = '{vld: !pend_cmd_q.we, owner: OWN_SPI};
        end else if (host_win) begin
            ram_en_d     = 1'b1;
            ram_we_d     = bus.host_we;
            ram_addr_d   = bus.host_addr[RAM_AW-1:0];
            ram_wdata_d  = bus.host_wdata;
            host_gnt_d   = 1'b1;
            last_grant_d = OWN_HOST;
            tag_d[0]     = '{vld: !bus.host_we, owner: OWN_HOST};
        end

        // Addresses are sampled into the pending command now, so later updates cannot disturb it.
        if (bus.spi_rx_valid) begin
            case (op)
                2'b00: wr_addr_d = payload[RAM_AW-1:0];
                2'b10: rd_addr_d = payload[RAM_AW-1:0];
                default: begin
                    if (spi_pend_q && !spi_win) begin
                        err_overflow_d = 1'b1;
                    end else begin
                        spi_pend_d = 1'b1;
                        if (op == 2'b01) pend_cmd_d = '{we: 1'b1, addr: wr_addr_q, wdata: payload};
                        else             pend_cmd_d = '{we: 1'b0, addr: rd_addr_q, wdata: '0};
                    end
                end
            endcase
        end

        if (tag_q[1].vld) begin
            if (tag_q[1].owner == OWN_SPI) begin
                spi_tx_data_d  = bus.ram_rdata;
                spi_tx_valid_d = 1'b1;
            end else begin
                host_rdata_d   = bus.ram_rdata;
                host_rvalid_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_addr_q      <= '0;
            rd_addr_q      <= '0;
            spi_pend_q     <= 1'b0;
            pend_cmd_q     <= '0;
            last_grant_q   <= OWN_SPI;
            tag_q          <= '0;
            ram_en_q       <= 1'b0;
            ram_we_q       <= 1'b0;
            ram_addr_q     <= '0;
            ram_wdata_q    <= '0;
            host_gnt_q     <= 1'b0;
            spi_tx_data_q  <= '0;
            spi_tx_valid_q <= 1'b0;
            host_rdata_q   <= '0;
            host_rvalid_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            wr_addr_q      <= wr_addr_d;
            rd_addr_q      <= rd_addr_d;
            spi_pend_q     <= spi_pend_d;
            pend_cmd_q     <= pend_cmd_d;
            last_grant_q   <= last_grant_d;
            tag_q          <= tag_d;
            ram_en_q       <= ram_en_d;
            ram_we_q       <= ram_we_d;
            ram_addr_q     <= ram_addr_d;
            ram_wdata_q    <= ram_wdata_d;
            host_gnt_q     <= host_gnt_d;
            spi_tx_data_q  <= spi_tx_data_d;
            spi_tx_valid_q <= spi_tx_valid_d;
            host_rdata_q   <= host_rdata_d;
            host_rvalid_q  <= host_rvalid_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign bus.ram_en       = ram_en_q;
    assign bus.ram_we       = ram_we_q;
    assign bus.ram_addr     = ram_addr_q;
    assign bus.ram_wdata    = ram_wdata_q;
    assign bus.host_gnt     = host_gnt_q;
    assign bus.host_rdata   = host_rdata_q;
    assign bus.host_rvalid  = host_rvalid_q;
    assign bus.spi_tx_data  = spi_tx_data_q;
    assign bus.spi_tx_valid = spi_tx_valid_q;
    assign bus.err_overflow = err_overflow_q;
endmodule
